// File: rtl/shadow_ray_scheduler.sv
// shadow_ray_scheduler: round-robin front end that shares one shadow-ray
// generator between N_REQ AABB test lanes. Hits are sent through the
// generator (start/valid exchange with a bounded wait). Misses skip the
// generator and come back as no-shadow results. One request in flight at a time.
module shadow_ray_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 24,
  parameter int Q_BITS  = 12,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_hit,
  input  logic [N_REQ*3*WIDTH-1:0] req_hit_point,
  input  logic [N_REQ*3*WIDTH-1:0] req_normal,
  output logic                     gen_start,
  output logic [3*WIDTH-1:0]       gen_hit_point,
  output logic [3*WIDTH-1:0]       gen_normal,
  input  logic                     gen_valid,
  input  logic [3*WIDTH-1:0]       gen_origin,
  input  logic [3*WIDTH-1:0]       gen_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_hit,
  output logic [3*WIDTH-1:0]       out_origin,
  output logic [3*WIDTH-1:0]       out_dir,
  output logic                     timeout_err,
  output logic                     busy
);

  localparam int VEC_W = 3 * WIDTH;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Fixed-point format is only carried through; reject nonsensical settings early.
  if (Q_BITS < 0 || Q_BITS >= WIDTH) begin : g_bad_qbits
    $error("shadow_ray_scheduler: Q_BITS must be in [0, WIDTH)");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("shadow_ray_scheduler: TIMEOUT must be >= 2");
  end
  if ((1 << TAG_W) != N_REQ) begin : g_bad_nreq
    $error("shadow_ray_scheduler: N_REQ must be a power of two matching TAG_W");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t             state_q;
  logic [TAG_W-1:0]   ptr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [VEC_W-1:0]   hp_q;
  logic [VEC_W-1:0]   nrm_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               gen_start_q;
  logic               out_valid_q;
  logic               out_hit_q;
  logic [VEC_W-1:0]   out_origin_q;
  logic [VEC_W-1:0]   out_dir_q;
  logic               timeout_err_q;

  // Per-lane views of the flattened operand buses.
  logic [VEC_W-1:0] lane_hp  [N_REQ];
  logic [VEC_W-1:0] lane_nrm [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign lane_hp[gi]  = req_hit_point[gi*VEC_W +: VEC_W];
    assign lane_nrm[gi] = req_normal[gi*VEC_W +: VEC_W];
  end

  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] scan_idx;
  logic             grant_found;
  logic             accept;

  // Round-robin pick: scanning down means the lane closest to ptr_q wins last.
  always_comb begin
    grant_idx   = ptr_q;
    scan_idx    = ptr_q;
    grant_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = ptr_q + TAG_W'(k);
      if (req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign accept    = (state_q == S_IDLE) && grant_found;
  assign req_ready = (accept && !reset) ? (N_REQ'(1) << grant_idx) : '0;

  // Scheduler FSM: accept, issue to generator, bounded wait, hold result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      tag_q         <= '0;
      hp_q          <= '0;
      nrm_q         <= '0;
      cnt_q         <= '0;
      gen_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_hit_q     <= 1'b0;
      out_origin_q  <= '0;
      out_dir_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      gen_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            hp_q  <= lane_hp[grant_idx];
            nrm_q <= lane_nrm[grant_idx];
            tag_q <= grant_idx;
            ptr_q <= grant_idx + TAG_W'(1);
            if (req_hit[grant_idx]) begin
              state_q     <= S_ISSUE;
              gen_start_q <= 1'b1;
            end else begin
              state_q      <= S_OUTPUT;
              out_valid_q  <= 1'b1;
              out_hit_q    <= 1'b0;
              out_origin_q <= '0;
              out_dir_q    <= '0;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still wins over the abort.
          if (gen_valid) begin
            out_origin_q <= gen_origin;
            out_dir_q    <= gen_dir;
            out_hit_q    <= 1'b1;
            out_valid_q  <= 1'b1;
            state_q      <= S_OUTPUT;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            out_origin_q  <= '0;
            out_dir_q     <= '0;
            out_hit_q     <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= S_OUTPUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gen_start     = gen_start_q;
  assign gen_hit_point = hp_q;
  assign gen_normal    = nrm_q;
  assign out_valid     = out_valid_q;
  assign out_tag       = tag_q;
  assign out_hit       = out_hit_q;
  assign out_origin    = out_origin_q;
  assign out_dir       = out_dir_q;
  assign timeout_err   = timeout_err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_shadow_ray_scheduler.sv
// Scoreboard bench for shadow_ray_scheduler: stimulus predicts each result
// from a lane-level model (round-robin pick, generator plan), a monitor
// compares whatever the DUT presents, and a generator model answers gen_start.
module tb_shadow_ray_scheduler;
  localparam int N  = 4;
  localparam int W  = 24;
  localparam int V  = 3 * W;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, req_hit;
  logic [N*V-1:0] req_hit_point, req_normal;
  logic           gen_start, gen_valid;
  logic [V-1:0]   gen_hit_point, gen_normal, gen_origin, gen_dir;
  logic           out_valid, out_ready, out_hit, timeout_err, busy;
  logic [1:0]     out_tag;
  logic [V-1:0]   out_origin, out_dir;

  shadow_ray_scheduler #(.N_REQ(N), .WIDTH(W), .Q_BITS(12), .TIMEOUT(TO), .TAG_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_hit(req_hit),
    .req_hit_point(req_hit_point), .req_normal(req_normal),
    .gen_start(gen_start), .gen_hit_point(gen_hit_point), .gen_normal(gen_normal),
    .gen_valid(gen_valid), .gen_origin(gen_origin), .gen_dir(gen_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_hit(out_hit),
    .out_origin(out_origin), .out_dir(out_dir), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           tag;
    bit           hit;
    logic [V-1:0] org;
    logic [V-1:0] dir;
    int           delay;
    bit           to;
    int           acc;
  } exp_t;

  typedef struct {
    int           lat;   // 0 = generator never answers
    logic [V-1:0] org;
    logic [V-1:0] dir;
    logic [V-1:0] hp;
    logic [V-1:0] nrm;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int n_vec = 0, n_err = 0;
  int m_ptr = 0, exp_starts = 0, seen_starts = 0, rdy_mode = 0, stray_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [V-1:0] rnd_vec();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[V-1:0];
  endfunction

  function automatic logic [N*V-1:0] rnd_lanes();
    logic [N*V-1:0] t;
    for (int i = 0; i < N; i++) t[i*V +: V] = rnd_vec();
    return t;
  endfunction

  // Present one request set, wait for the accept, and record the prediction.
  task automatic do_req(input logic [N-1:0] mask, input logic [N-1:0] hits,
                        input logic [N*V-1:0] hp, input logic [N*V-1:0] nrm,
                        input int lat, input logic [V-1:0] org, input logic [V-1:0] dir);
    int g;
    bit got;
    exp_t e;
    plan_t p;
    logic [N-1:0] one_hot;
    got = 0;
    g = pick(mask, m_ptr);
    req_valid = mask; req_hit = hits; req_hit_point = hp; req_normal = nrm;
    for (int n = 0; n < 400 && !got; n++) begin
      #1;
      if (req_ready != '0) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      req_valid = '0;
      return;
    end
    one_hot = '0;
    one_hot[g] = 1'b1;
    chk("grant", req_ready, one_hot);
    e.tag   = g;
    e.hit   = hits[g] && (lat > 0);
    e.org   = e.hit ? org : '0;
    e.dir   = e.hit ? dir : '0;
    e.delay = !hits[g] ? 1 : (lat > 0 ? lat + 2 : TO + 2);
    e.to    = hits[g] && (lat == 0);
    e.acc   = cyc;
    if (hits[g]) begin
      p.lat = lat; p.org = org; p.dir = dir;
      p.hp = hp[g*V +: V]; p.nrm = nrm[g*V +: V];
      plan_q.push_back(p);
      exp_starts++;
    end
    exp_q.push_back(e);
    m_ptr = (g + 1) % N;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Consumer backpressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b0;
    end
  end

  // Generator model: answers each gen_start after the planned latency.
  initial begin
    int cd;
    int stray_seen;
    plan_t p;
    cd = 0; stray_seen = 0;
    gen_valid = 1'b0; gen_origin = '0; gen_dir = '0;
    forever begin
      @(negedge clk);
      gen_valid = 1'b0;
      if (reset) cd = 0;
      if (gen_start) begin
        seen_starts++;
        if (plan_q.size() == 0) chk("gen_start_unexpected", 1, 0);
        else begin
          p = plan_q.pop_front();
          chk("gen_hit_point", gen_hit_point, p.hp);
          chk("gen_normal", gen_normal, p.nrm);
          cd = p.lat;
          gen_origin = p.org;
          gen_dir = p.dir;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          gen_valid = 1'b1;
          chk("gen_hit_point_hold", gen_hit_point, p.hp);
        end
      end
      if (stray_seen != stray_cnt) begin
        stray_seen = stray_cnt;
        gen_valid = 1'b1;
        gen_origin = rnd_vec();
        gen_dir = rnd_vec();
      end
    end
  end

  // Monitor: compares presented results against the scoreboard head.
  initial begin
    bit prev_ov, prev_hs, rise;
    exp_t e;
    prev_ov = 0; prev_hs = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_ov = 0; prev_hs = 0;
        continue;
      end
      if (prev_hs) chk("out_valid_drop", out_valid, 0);
      rise = out_valid && !prev_ov;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = exp_q[0];
          chk("out_tag", out_tag, e.tag);
          chk("out_hit", out_hit, e.hit);
          chk("out_origin", out_origin, e.org);
          chk("out_dir", out_dir, e.dir);
          if (rise) chk("latency", cyc - e.acc, e.delay);
          if (rise || timeout_err) chk("timeout_err", timeout_err, rise && e.to);
          if (out_ready) begin
            void'(exp_q.pop_front());
            $display("txn tag=%0d hit=%0d timeout=%0d origin=%0h dir=%0h", e.tag, e.hit, e.to, e.org, e.dir);
          end
        end
      end else if (timeout_err) chk("timeout_err_stray", 1, 0);
      prev_hs = out_valid && out_ready;
      prev_ov = out_valid;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*V-1:0] hpv, nrv;
    logic [V-1:0]   o, d;
    logic [N-1:0]   mask, hits;
    int lat;
    reset = 1'b1;
    req_valid = '0; req_hit = '0; req_hit_point = '0; req_normal = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {req_ready, gen_start, out_valid, out_tag, out_hit, timeout_err, busy}, 0);
    chk("reset_origin", out_origin, 0);
    chk("reset_dir", out_dir, 0);
    chk("reset_gen_ops", {gen_hit_point, gen_normal}, 0);
    reset = 1'b0;
    @(negedge clk);

    // All lanes valid, all misses: round-robin 0,1,2,3,0.
    for (int i = 0; i < 5; i++) do_req(4'hF, 4'h0, rnd_lanes(), rnd_lanes(), 0, '0, '0);
    drain();

    // Single hit on lane 2, generator latency 3.
    hpv = rnd_lanes(); nrv = rnd_lanes();
    hpv[2*V +: V] = {24'h003000, 24'h002000, 24'h001000};
    nrv[2*V +: V] = {24'h000000, 24'h000000, 24'h001000};
    o = {24'h003000, 24'h002000, 24'h001001};
    d = {24'h000000, 24'h000000, 24'h000800};
    do_req(4'b0100, 4'b0100, hpv, nrv, 3, o, d);
    drain();

    // Miss on lane 1.
    do_req(4'b0010, 4'b0000, rnd_lanes(), rnd_lanes(), 0, '0, '0);
    drain();

    // Generator never answers, then a normal request.
    do_req(4'b1000, 4'b1000, rnd_lanes(), rnd_lanes(), 0, rnd_vec(), rnd_vec());
    drain();
    do_req(4'b0001, 4'b0001, rnd_lanes(), rnd_lanes(), 1, rnd_vec(), rnd_vec());
    drain();

    // Output held under backpressure; no accepts, stray gen_valid ignored.
    rdy_mode = 2;
    do_req(4'b0100, 4'b0100, rnd_lanes(), rnd_lanes(), 2, rnd_vec(), rnd_vec());
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1 chk("no_accept_in_output", req_ready, 0);
      if (i == 4) stray_cnt++;
    end
    req_valid = '0;
    rdy_mode = 0;
    drain();

    // Reset while waiting on the generator.
    do_req(4'b0010, 4'b0010, rnd_lanes(), rnd_lanes(), 0, rnd_vec(), rnd_vec());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    plan_q.delete();
    m_ptr = 0;
    @(negedge clk);
    #1;
    chk("midreset_ctrl", {req_ready, gen_start, out_valid, out_tag, out_hit, timeout_err, busy}, 0);
    chk("midreset_origin", out_origin, 0);
    chk("midreset_dir", out_dir, 0);
    reset = 1'b0;
    @(negedge clk);
    stray_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 chk("idle_after_reset", {busy, out_valid}, 0);
    end
    do_req(4'hF, 4'h0, rnd_lanes(), rnd_lanes(), 0, '0, '0);
    drain();

    // Randomised traffic with random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      mask = N'($urandom_range(1, 15));
      hits = N'($urandom());
      lat  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      do_req(mask, hits, rnd_lanes(), rnd_lanes(), lat, rnd_vec(), rnd_vec());
    end
    rdy_mode = 0;
    drain();
    repeat (3) @(negedge clk);
    chk("gen_start_count", seen_starts, exp_starts);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/shadow_ray_scheduler.md
Name: shadow_ray_scheduler

Overview:
- Shares one shadow-ray generator datapath between N_REQ AABB test lanes.
- Accepts per-lane hit results with a round-robin arbiter and sequences the generator start/valid exchange.
- Bounds every generator wait with a timeout and returns the generated ray, tagged with the lane index, on a valid/ready output.
- Misses bypass the generator and are returned as no-shadow results.

Parameters:
- N_REQ, 4, number of requesting AABB lanes (power of 2, ≥2).
- WIDTH, 24, fixed-point word width (Q_BITS fractional bits).
- Q_BITS, 12, fractional bits; passed through, no arithmetic here.
- TIMEOUT, 64, max cycles in WAIT before abort (≥2).
- TAG_W, $clog2(N_REQ), lane tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  lane i has a result.
- req_ready  out  N_REQ  one-hot grant/accept.
- req_hit  in  N_REQ  lane i AABB hit flag.
- req_hit_point  in  N_REQ*3*WIDTH  lane i {x,y,z}; x in LSBs.
- req_normal  in  N_REQ*3*WIDTH  lane i face normal {x,y,z}.
- gen_start  out  1  one-cycle start pulse to the generator.
- gen_hit_point  out  3*WIDTH  latched hit point.
- gen_normal  out  3*WIDTH  latched normal.
- gen_valid  in  1  generator result valid (single-cycle pulse).
- gen_origin  in  3*WIDTH  generator offset origin.
- gen_dir  in  3*WIDTH  generator direction.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_tag  out  TAG_W  lane that produced the result.
- out_hit  out  1  1 = shadow ray valid, 0 = miss or aborted.
- out_origin  out  3*WIDTH  shadow ray origin (0 when out_hit=0).
- out_dir  out  3*WIDTH  shadow ray direction (0 when out_hit=0).
- timeout_err  out  1  one-cycle pulse on generator abort.
- busy  out  1  state != IDLE.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - State = IDLE; round-robin pointer = 0.
  - All outputs 0: req_ready, gen_start, out_valid, out_tag, out_hit, out_origin, out_dir, timeout_err, busy.
  - Latched operands and timeout counter = 0.
- Reset mid-operation: in-flight request is discarded. A later stray gen_valid in IDLE is ignored.
- State machine: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE:
  - Grant g = first lane with req_valid=1, scanning from the pointer upward with wrap (N_REQ-1 → 0).
  - req_ready is combinational: one-hot at g, all zero if no lane is valid. Handshake completes in the same cycle.
  - On accept: latch hit_point, normal, hit, tag=g; pointer ← (g+1) mod N_REQ.
  - Next state: ISSUE if hit=1, else OUTPUT with out_hit=0 and zero origin/dir.
- ISSUE:
  - gen_start=1 for exactly one cycle; gen_hit_point/gen_normal are driven from the latches and held stable until leaving WAIT.
  - Clear timeout counter; next state WAIT.
- WAIT:
  - gen_valid=1: capture gen_origin/gen_dir into out regs, out_hit=1, next state OUTPUT.
  - Otherwise the counter increments. At counter == TIMEOUT-1 with no gen_valid: timeout_err pulses next cycle, out_hit=0, origin/dir zeroed, next state OUTPUT (tag preserved).
  - gen_valid on the final timeout cycle wins over the timeout.
- OUTPUT:
  - out_valid=1; out_tag/out_hit/out_origin/out_dir held stable until out_ready=1.
  - On handshake, next state IDLE; out_valid drops the following cycle.
- gen_valid outside WAIT is ignored.
- No new request is accepted outside IDLE, so at most one request is in flight.
- Minimum turnaround:
  - Hit: accept (IDLE) → ISSUE → WAIT for generator latency L ≥ 1 → OUTPUT. out_valid rises L+2 cycles after accept.
  - Miss: out_valid rises 1 cycle after accept; the next accept is possible 2 cycles after accept if out_ready=1.
- Fairness: a lane that stays valid is granted within N_REQ accepts.
- busy=1 in ISSUE, WAIT and OUTPUT.

Test Plan:
- Single hit lane 2: hit_point=(0x001000,0x002000,0x003000), normal=(0x001000,0,0); generator returns gen_valid after 3 cycles with origin=(0x001001,0x002000,0x003000), dir=(0x000800,0,0) → gen_start pulses once; out_valid 5 cycles after accept with tag=2, out_hit=1, values equal to the generator's.
- Miss lane 1, out_ready=1 → no gen_start; out_valid 1 cycle after accept with tag=1, out_hit=0, origin/dir=0; back to IDLE.
- All 4 lanes valid continuously, every request a miss, out_ready=1 → grant order 0,1,2,3,0; each req_ready one-hot.
- gen_valid never returned, TIMEOUT=64 → timeout_err pulses once 64 cycles after WAIT entry; out_hit=0 with the correct tag; the next request is accepted normally.
- out_ready held low 10 cycles in OUTPUT → out_* stable; req_ready=0 throughout despite req_valid=4'b1111; stray gen_valid pulse ignored.
- reset asserted in WAIT → next cycle all outputs 0 and pointer=0; gen_valid arriving 2 cycles later produces no out_valid.
